seq_mult_ctrl: RTL and testbench
================================

// Module: seq_mult_ctrl
// PURPOSE
//  Sequential shift-and-add 8x8 multiplier controller. It time-shares one adder8bit
//  instance (MODE driven by this block) over 8 steps, replacing the 3-adder array_mult
//  for area. Operands use a valid/ready handshake; the 16-bit product is held until accepted.
// PARAMETERS
//  WIDTH      8  operand width; only 8 is supported (matches adder8bit)
//  ZERO_SKIP  0  1: an operand of 0 skips CALC; the result is ready the cycle after accept
// PORTS
//  CLK        in   1   clock; all state updates on the rising edge
//  RST        in   1   synchronous, active-high reset
//  IN_VALID   in   1   A/B operands valid
//  IN_READY   out  1   block can accept operands (=1 only in IDLE)
//  A          in   8   multiplicand
//  B          in   8   multiplier
//  OUT_VALID  out  1   P valid (=1 only in DONE)
//  OUT_READY  in   1   consumer takes P
//  P          out  16  product {P_HI,P_LO}
//  BUSY       out  1   =1 in CALC or DONE
// BEHAVIOUR
//  - Registers: MCAND[7:0], P_HI[7:0], P_LO[7:0], CNT[2:0], STATE {IDLE,CALC,DONE}.
//  - Reset: STATE=IDLE, all registers=0, IN_READY=1, OUT_VALID=0, BUSY=0, P=0.
//    RST mid-CALC or mid-DONE aborts the operation and drops the result. RST has priority.
//  - IDLE: if IN_VALID, the accept edge loads MCAND=A, P_HI=0, P_LO=B, CNT=0 -> CALC.
//    If ZERO_SKIP=1 and (A==0 or B==0): load P_HI=0, P_LO=0 and go -> DONE.
//  - CALC (one step per cycle):
//    - Adder inputs: A=P_HI, B=MCAND, MODE=0.
//    - If P_LO[0]: {P_HI,P_LO} <= {IN,S,P_LO[7:1]}; else {P_HI,P_LO} <= {IN,P_HI,P_LO[7:1]}.
//    - Unsigned: IN = P_LO[0] ? CO : 0.
//    - CNT increments each step. Step with CNT==7 -> DONE.
//  - Latency: accept at edge T0; steps at edges T1..T8; OUT_VALID=1 from T8 on.
//    The fixed latency is 8 cycles, independent of operand values, except for the ZERO_SKIP case.
//  - DONE: P and OUT_VALID hold stable while OUT_READY=0 (unbounded stall).
//    On OUT_VALID&&OUT_READY -> IDLE. IN_READY=0 in DONE, so there is no result/operand overlap.
//    The next accept can occur at the earliest one cycle after the output handshake.
//  - IN_VALID outside IDLE is ignored. A/B are sampled only on the accept edge, and later
//    changes have no effect.
//  - P is driven combinationally from {P_HI,P_LO} and is only meaningful while OUT_VALID=1.
//  - Arithmetic is carry-exact: the 9-bit sum {CO,S} is never truncated.
//    0xFF*0xFF = 0xFE01 with no overflow.
// CONFIGURATION
//  SEQ_MULT_SIGNED_EN defined: A, B and P are two's-complement.
//    - Steps CNT=0..6 add MCAND; step CNT=7 subtracts it (MODE=1 when CNT==7 && P_LO[0]).
//    - Shift-in: IN = P_LO[0] ? (P_HI[7]^BX7^CO) : P_HI[7], with BX7 = MCAND[7]^MODE
//      (sign-extended 9th sum bit).
//  SEQ_MULT_SIGNED_EN undefined: unsigned only; MODE is tied to 0. Latency is identical in both modes.
// TESTING
//  1 RST high 2 cycles -> IN_READY=1, OUT_VALID=0, BUSY=0, P=0x0000.
//  2 A=13, B=11, IN_VALID pulse, OUT_READY=1 -> OUT_VALID 8 cycles after accept, P=0x008F.
//  3 A=0xFF, B=0xFF, OUT_READY=0 for 5 cycles -> P=0xFE01 held stable; IN_VALID ignored;
//    after OUT_READY=1, back to IDLE.
//  4 A=0x5A, B=0x00: ZERO_SKIP=0 -> P=0x0000 after 8 cycles;
//    ZERO_SKIP=1 -> OUT_VALID 1 cycle after accept.
//  5 Accept A=7, B=9, assert RST at step 4 -> IDLE, OUT_VALID never rises.
//    Then A=2, B=3 -> P=0x0006.
//  6 SEQ_MULT_SIGNED_EN: A=-3 (0xFD), B=5 -> P=0xFFF1; A=0x80, B=0x80 -> P=0x4000;
//    A=0x7F, B=0x80 -> P=0xC080.

Source files
------------

// File: rtl/seq_mult_ctrl_if.sv
// rtl/seq_mult_ctrl_if.sv - operand/product handshake bundle for seq_mult_ctrl
interface seq_mult_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - 8-step shift-and-add 8x8 multiplier sharing one adder8bit
// Optional signed (two's-complement) operation when SEQ_MULT_SIGNED_EN is defined.
module adder8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       mode,
    output logic [7:0] s,
    output logic       co
);
    // mode=1 computes a - b as a + ~b + 1; co is the true 9th bit of that sum
    assign {co, s} = {1'b0, a} + {1'b0, b ^ {8{mode}}} + {8'd0, mode};
endmodule

module seq_mult_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit ZERO_SKIP = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mcand, mcand_nxt;
    logic [WIDTH-1:0]  p_hi, p_hi_nxt;
    logic [WIDTH-1:0]  p_lo, p_lo_nxt;
    logic [2:0]        cnt, cnt_nxt;

    logic [WIDTH-1:0]  sum;
    logic              carry;
    logic              add_mode;
    logic              shift_in;
    logic [WIDTH-1:0]  upper;

    adder8bit u_adder (
        .a    (p_hi),
        .b    (mcand),
        .mode (add_mode),
        .s    (sum),
        .co   (carry)
    );

`ifdef SEQ_MULT_SIGNED_EN
    // Last partial product carries negative weight, so it is subtracted.
    assign add_mode = (state == CALC) && (cnt == 3'd7) && p_lo[0];
    assign shift_in = p_lo[0] ? (p_hi[WIDTH-1] ^ (mcand[WIDTH-1] ^ add_mode) ^ carry)
                              : p_hi[WIDTH-1];
`else
    assign add_mode = 1'b0;
    assign shift_in = p_lo[0] ? carry : 1'b0;
`endif

    assign upper = p_lo[0] ? sum : p_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            mcand <= mcand_nxt;
            p_hi  <= p_hi_nxt;
            p_lo  <= p_lo_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mcand_nxt = mcand;
        p_hi_nxt  = p_hi;
        p_lo_nxt  = p_lo;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_nxt = bus.a;
                    p_hi_nxt  = '0;
                    p_lo_nxt  = bus.b;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                    if (ZERO_SKIP && ((bus.a == '0) || (bus.b == '0))) begin
                        p_lo_nxt  = '0;
                        state_nxt = DONE;
                    end
                end
            end
            CALC: begin
                p_hi_nxt = {shift_in, upper[WIDTH-1:1]};
                p_lo_nxt = {upper[0], p_lo[WIDTH-1:1]};
                cnt_nxt  = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == CALC) || (state == DONE);
    assign bus.p         = {p_hi, p_lo};
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - directed self-checking bench for seq_mult_ctrl
module tb_seq_mult_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sel = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl_if bus0 ();
    seq_mult_ctrl_if busz ();

    assign bus0.in_valid  = in_valid & ~sel;
    assign bus0.a         = a;
    assign bus0.b         = b;
    assign bus0.out_ready = out_ready;
    assign busz.in_valid  = in_valid & sel;
    assign busz.a         = a;
    assign busz.b         = b;
    assign busz.out_ready = out_ready;

    seq_mult_ctrl #(.WIDTH(8), .ZERO_SKIP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_mult_ctrl #(.WIDTH(8), .ZERO_SKIP(1'b1)) dutz (.clk(clk), .rst(rst), .bus(busz));

    wire        obs_in_ready  = sel ? busz.in_ready  : bus0.in_ready;
    wire        obs_out_valid = sel ? busz.out_valid : bus0.out_valid;
    wire        obs_busy      = sel ? busz.busy      : bus0.busy;
    wire [15:0] obs_p         = sel ? busz.p         : bus0.p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [7:0] ta,
                         input logic [7:0] tb_b, input logic [15:0] exp_p, input int exp_lat);
        int n;
        sel       = s;
        a         = ta;
        b         = tb_b;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        chk({tag, "_in_ready"}, obs_in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_b;
        n = 0;
        while (!obs_out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_p"}, obs_p, exp_p);
        chk({tag, "_busy"}, obs_busy, 1);
        tick();
        chk({tag, "_back_idle"}, obs_in_ready, 1);
        chk({tag, "_valid_drop"}, obs_out_valid, 0);
    endtask

    initial begin
        int   n;
        logic seen;
        logic [15:0] held;

        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_p", bus0.p, 16'h0000);

        do_op("m13x11", 1'b0, 8'd13, 8'd11, 16'h008F, 8);

        // stalled output with ignored operands
        sel       = 1'b0;
        a         = 8'hFF;
        b         = 8'hFF;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!bus0.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("ffxff_latency", n, 8);
        held = bus0.p;
        chk("ffxff_p", held, 16'hFE01);
        a        = 8'h03;
        b        = 8'h04;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", bus0.out_valid, 1);
            chk("stall_p", bus0.p, 16'hFE01);
            chk("stall_in_ready", bus0.in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_release_idle", bus0.in_ready, 1);
        chk("stall_release_busy", bus0.busy, 0);

        // zero operand without and with skipping
        do_op("zero_noskip", 1'b0, 8'h5A, 8'h00, 16'h0000, 8);
        do_op("zero_skip", 1'b1, 8'h5A, 8'h00, 16'h0000, 0);
        do_op("zero_skip_a", 1'b1, 8'h00, 8'h37, 16'h0000, 0);
        do_op("skip_nonzero", 1'b1, 8'd13, 8'd11, 16'h008F, 8);

        // reset in the middle of CALC
        sel       = 1'b0;
        a         = 8'd7;
        b         = 8'd9;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy_before", bus0.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", bus0.in_ready, 1);
        chk("abort_busy", bus0.busy, 0);
        chk("abort_p", bus0.p, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus0.out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", seen, 0);
        do_op("m2x3", 1'b0, 8'd2, 8'd3, 16'h0006, 8);

`ifdef SEQ_MULT_SIGNED_EN
        do_op("m_neg3x5", 1'b0, 8'hFD, 8'h05, 16'hFFF1, 8);
        do_op("m80x80", 1'b0, 8'h80, 8'h80, 16'h4000, 8);
        do_op("m7fx80", 1'b0, 8'h7F, 8'h80, 16'hC080, 8);
`else
        do_op("m_fdx5", 1'b0, 8'hFD, 8'h05, 16'h04F1, 8);
        do_op("m80x80", 1'b0, 8'h80, 8'h80, 16'h4000, 8);
        do_op("m7fx80", 1'b0, 8'h7F, 8'h80, 16'h3F80, 8);
`endif
        do_op("m01xff", 1'b0, 8'h01, 8'hFF, 16'h00FF, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
